fpaddsub_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one pipelined FP add/sub datapath (single precision) between NREQ requesters.
- Accepts at most one operation per cycle and registers it onto the datapath issue port.
- Tracks each in-flight operation's requester tag through a fixed-latency shadow pipeline.
- Steers each datapath result back to the requester that issued it. Sits between the arithmetic clients and the FPAddSub pipeline.

---
 rtl/fpaddsub_rr_scheduler_if.sv | 26 ++
 rtl/fpaddsub_rr_scheduler.sv | 69 ++++++
 tb/tb_fpaddsub_rr_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fpaddsub_rr_scheduler_if.sv
// fpaddsub_rr_scheduler_if: requester, datapath issue/result and response signals of the scheduler
interface fpaddsub_rr_scheduler_if #(parameter int NREQ = 4);
   logic                 enable;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      req_op;
   logic                 dp_en;
   logic                 dp_valid;
   logic [31:0]          dp_a;
   logic [31:0]          dp_b;
   logic                 dp_op;
   logic [31:0]          dp_result;
   logic [NREQ-1:0]      resp_valid;
   logic [31:0]          resp_data;
   logic                 busy;
   modport master (
      output enable, req_valid, req_a, req_b, req_op, dp_result,
      input  req_ready, dp_en, dp_valid, dp_a, dp_b, dp_op, resp_valid, resp_data, busy
   );
   modport slave (
      input  enable, req_valid, req_a, req_b, req_op, dp_result,
      output req_ready, dp_en, dp_valid, dp_a, dp_b, dp_op, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/fpaddsub_rr_scheduler.sv
// fpaddsub_rr_scheduler: round-robin sharing of one pipelined FP add/sub datapath with tag-steered results
module fpaddsub_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int TAGW = 2,
   parameter int LAT  = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   fpaddsub_rr_scheduler_if.slave bus
);
   logic [TAGW-1:0] ptr;
   logic [TAGW-1:0] gidx;
   logic [TAGW-1:0] cand;
   logic [TAGW-1:0] nxt;
   logic [TAGW-1:0] dp_tag;
   logic            hit;
   logic [LAT-1:0]  sv_valid;
   logic [TAGW-1:0] sv_tag [LAT];
   always_comb begin
      hit  = 1'b0;
      gidx = '0;
      cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = TAGW'((int'(ptr) + k) % NREQ);
         if (!hit && bus.enable && bus.req_valid[cand]) begin
            hit  = 1'b1;
            gidx = cand;
         end
      end
   end
   assign nxt           = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
   assign bus.req_ready = (hit && rst_n) ? (NREQ'(1) << gidx) : '0;
   assign bus.dp_en     = bus.enable;
   assign bus.busy      = bus.dp_valid | (|sv_valid);
   // The shadow pipeline mirrors the datapath latency so the tag lines up with DpResult.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr            <= '0;
         bus.dp_valid   <= 1'b0;
         bus.dp_a       <= '0;
         bus.dp_b       <= '0;
         bus.dp_op      <= 1'b0;
         dp_tag         <= '0;
         sv_valid       <= '0;
         for (int s = 0; s < LAT; s++) sv_tag[s] <= '0;
         bus.resp_valid <= '0;
         bus.resp_data  <= '0;
      end else if (bus.enable) begin
         bus.dp_valid <= hit;
         if (hit) begin
            ptr       <= nxt;
            bus.dp_a  <= bus.req_a[32*gidx +: 32];
            bus.dp_b  <= bus.req_b[32*gidx +: 32];
            bus.dp_op <= bus.req_op[gidx];
            dp_tag    <= gidx;
         end
         sv_valid[0] <= bus.dp_valid;
         sv_tag[0]   <= dp_tag;
         for (int s = 1; s < LAT; s++) begin
            sv_valid[s] <= sv_valid[s-1];
            sv_tag[s]   <= sv_tag[s-1];
         end
         bus.resp_valid <= sv_valid[LAT-1] ? (NREQ'(1) << sv_tag[LAT-1]) : '0;
         if (sv_valid[LAT-1]) bus.resp_data <= bus.dp_result;
      end
   end
   a_tag_range: assert property (@(posedge clk) disable iff (!rst_n)
      sv_valid[LAT-1] |-> int'(sv_tag[LAT-1]) < NREQ);
endmodule

// File: tb/tb_fpaddsub_rr_scheduler.sv
// tb_fpaddsub_rr_scheduler: directed vectors and corner sequences for the round-robin FP add/sub scheduler
module tb_fpaddsub_rr_scheduler;
   localparam int NREQ = 4;
   localparam int TAGW = 2;
   localparam int LAT  = 4;
   localparam int D    = LAT + 2;
   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] res;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [NREQ-1:0] exp_gnt;
   logic [NREQ-1:0] ref_v [D];
   logic [31:0]     ref_d [D];
   logic [31:0]     dp_pipe [LAT];
   logic [NREQ-1:0] skip_exp [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
   vec_t            vecs [4];
   fpaddsub_rr_scheduler_if #(.NREQ(NREQ)) bus ();
   fpaddsub_rr_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
      case ({a, b, op})
         {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000;
         {32'h40400000, 32'h3F800000, 1'b1}: return 32'h40000000;
         {32'h40000000, 32'h40000000, 1'b0}: return 32'h40800000;
         {32'h40800000, 32'h40000000, 1'b1}: return 32'h40000000;
         default: return a ^ {b[15:0], b[31:16]} ^ {31'b0, op};
      endcase
   endfunction
   function automatic int idx_of(input logic [NREQ-1:0] m);
      for (int i = 0; i < NREQ; i++) if (m[i]) return i;
      return 0;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic cyc(input logic [NREQ-1:0] v, input logic en, input logic [NREQ-1:0] g, input string nm);
      bus.req_valid = v;
      bus.enable    = en;
      exp_gnt       = g;
      #1;
      chk(nm, bus.req_ready, g);
      @(posedge clk);
      #1;
   endtask
   // Model datapath: fixed LAT-stage pipe advancing on dp_en
   always @(posedge clk) begin
      if (bus.dp_en) begin
         dp_pipe[0] <= fp_model(bus.dp_a, bus.dp_b, bus.dp_op);
         for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
      end
   end
   assign bus.dp_result = dp_pipe[LAT-1];
   // Expected response timeline built from the bench's own intended grants
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) begin
            ref_v[i] <= '0;
            ref_d[i] <= '0;
         end
      end else if (bus.enable) begin
         ref_v[0] <= exp_gnt;
         ref_d[0] <= fp_model(bus.req_a[32*idx_of(exp_gnt) +: 32], bus.req_b[32*idx_of(exp_gnt) +: 32],
                              bus.req_op[idx_of(exp_gnt)]);
         for (int i = 1; i < D; i++) begin
            ref_v[i] <= ref_v[i-1];
            ref_d[i] <= ref_d[i-1];
         end
      end
   end
   always @(negedge clk) begin
      logic b;
      b = 1'b0;
      for (int i = 0; i <= LAT; i++) b = b | (|ref_v[i]);
      chk("mon_resp_valid", bus.resp_valid, ref_v[D-1]);
      if (|ref_v[D-1]) chk("mon_resp_data", bus.resp_data, ref_d[D-1]);
      chk("mon_busy", bus.busy, b);
   end
   initial begin
      rst_n         = 1'b1;
      bus.enable    = 1'b1;
      bus.req_valid = '0;
      bus.req_op    = '0;
      exp_gnt       = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[32*i +: 32] = 32'h3F80_0000 + 32'(i);
         bus.req_b[32*i +: 32] = 32'h4000_0000 + 32'(i * 3);
      end
      vecs[0] = '{1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
      vecs[1] = '{3, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
      vecs[2] = '{0, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000};
      vecs[3] = '{2, 32'h40800000, 32'h40000000, 1'b1, 32'h40000000};
      #1 rst_n = 1'b0;
      bus.req_valid = '1;
      @(posedge clk);
      #1;
      chk("rst_ready", bus.req_ready, 4'b0);
      chk("rst_dp_valid", bus.dp_valid, 1'b0);
      chk("rst_dp_a", bus.dp_a, 32'h0);
      chk("rst_dp_b", bus.dp_b, 32'h0);
      chk("rst_dp_op", bus.dp_op, 1'b0);
      chk("rst_resp_valid", bus.resp_valid, 4'b0);
      chk("rst_resp_data", bus.resp_data, 32'h0);
      chk("rst_busy", bus.busy, 1'b0);
      bus.req_valid = '0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
         bus.req_a[32*vecs[n].id +: 32] = vecs[n].a;
         bus.req_b[32*vecs[n].id +: 32] = vecs[n].b;
         bus.req_op[vecs[n].id]         = vecs[n].op;
         cyc(NREQ'(1) << vecs[n].id, 1'b1, NREQ'(1) << vecs[n].id, "vec_ready");
         chk("vec_dp_valid", bus.dp_valid, 1'b1);
         chk("vec_dp_a", bus.dp_a, vecs[n].a);
         chk("vec_dp_b", bus.dp_b, vecs[n].b);
         chk("vec_dp_op", bus.dp_op, vecs[n].op);
         for (int i = 1; i <= LAT; i++) begin
            cyc('0, 1'b1, '0, "vec_idle_ready");
            chk("vec_early_resp", bus.resp_valid, 4'b0);
            if (i == 1) chk("vec_dp_valid_drop", bus.dp_valid, 1'b0);
         end
         cyc('0, 1'b1, '0, "vec_idle_ready");
         chk("vec_resp_valid", bus.resp_valid, NREQ'(1) << vecs[n].id);
         chk("vec_resp_data", bus.resp_data, vecs[n].res);
         cyc('0, 1'b1, '0, "vec_idle_ready");
         chk("vec_resp_once", bus.resp_valid, 4'b0);
         chk("vec_busy_idle", bus.busy, 1'b0);
      end
      cyc(4'b0001, 1'b1, 4'b0001, "ptr_set");
      for (int i = 0; i < 4; i++) cyc(4'b0101, 1'b1, skip_exp[i], "skip_ready");
      repeat (LAT + 3) cyc('0, 1'b1, '0, "skip_drain");
      cyc('1, 1'b1, 4'b0010, "stall_issue");
      cyc('1, 1'b1, 4'b0100, "stall_issue");
      chk("stall_dp_valid", bus.dp_valid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc('1, 1'b0, '0, "stall_ready");
         chk("stall_dp_valid_hold", bus.dp_valid, 1'b1);
         chk("stall_dp_a_hold", bus.dp_a, bus.req_a[64 +: 32]);
         chk("stall_dp_en", bus.dp_en, 1'b0);
         chk("stall_busy", bus.busy, 1'b1);
         chk("stall_no_resp", bus.resp_valid, 4'b0);
      end
      for (int d = 0; d < LAT + 3; d++) begin
         cyc('0, 1'b1, '0, "stall_drain");
         chk("stall_resp", bus.resp_valid, d == 3 ? 4'b0010 : d == 4 ? 4'b0100 : 4'b0000);
      end
      cyc('1, 1'b1, 4'b1000, "mid_issue");
      cyc('1, 1'b1, 4'b0001, "mid_issue");
      cyc('1, 1'b1, 4'b0010, "mid_issue");
      #2 rst_n = 1'b0;
      exp_gnt = '0;
      #1;
      chk("mid_rst_ready", bus.req_ready, 4'b0);
      chk("mid_rst_dp_valid", bus.dp_valid, 1'b0);
      chk("mid_rst_dp_a", bus.dp_a, 32'h0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_resp_valid", bus.resp_valid, 4'b0);
      chk("mid_rst_resp_data", bus.resp_data, 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < LAT + 3; i++) begin
         cyc('0, 1'b1, '0, "post_rst_ready");
         chk("post_rst_no_resp", bus.resp_valid, 4'b0);
      end
      for (int i = 0; i < 8; i++) begin
         cyc('1, 1'b1, NREQ'(1) << (i % 4), "rr_ready");
         chk("rr_resp", bus.resp_valid, i >= 5 ? NREQ'(1) << ((i - 5) % 4) : 4'b0);
      end
      for (int d = 0; d < LAT + 3; d++) begin
         cyc('0, 1'b1, '0, "rr_drain");
         chk("rr_resp", bus.resp_valid, d <= 4 ? NREQ'(1) << ((3 + d) % 4) : 4'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
